// File: rtl/cached_ram_pkg.sv
// Shared geometry helpers and the cache line record for cached_ram.
package cached_ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 7;
  localparam int DEF_CACHE_SIZE = 16;
  localparam int DEF_LINE_SIZE  = 4;

  function automatic int offset_w(input int line_size);
    return $clog2(line_size);
  endfunction

  function automatic int index_w(input int cache_size);
    return $clog2(cache_size);
  endfunction

  function automatic int tag_w(input int addr_bits, input int cache_size, input int line_size);
    return addr_bits - index_w(cache_size) - offset_w(line_size);
  endfunction

  // Line record for the default geometry; the top derives the same shape from its parameters.
  typedef struct packed {
    logic                                                 valid;
    logic [DEF_ADDR_BITS-$clog2(DEF_CACHE_SIZE)-$clog2(DEF_LINE_SIZE)-1:0] tag;
    logic [DEF_LINE_SIZE-1:0][DEF_DATA_WIDTH-1:0]         data;
  } cache_line_t;

endpackage

// File: rtl/cached_ram_store.sv
// Backing word memory: one synchronous write port and a combinational whole-line read.
module cached_ram_store
  import cached_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 7,
  parameter int LINE_SIZE  = 4,
  localparam int OFFSET_W  = offset_w(LINE_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 wr_en,
  input  logic [ADDR_BITS-1:0]                 wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [ADDR_BITS-OFFSET_W-1:0]        line_addr,
  output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] line_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Contents start at zero from configuration; reset deliberately leaves them alone.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < LINE_SIZE; gi++) begin : g_line_rd
      assign line_data[gi] = mem_q[{line_addr, OFFSET_W'(gi)}];
    end
  endgenerate

endmodule

// File: rtl/cached_ram.sv
// Word RAM with a direct-mapped, write-through, write-allocate cache; 1-cycle read latency.
module cached_ram
  import cached_ram_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int CACHE_SIZE      = 16,
  parameter int CACHE_LINE_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-2:0] addr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  writeEnable,
  output logic [DATA_WIDTH-1:0] dataOut
);

  localparam int AW       = ADDR_WIDTH - 1;
  localparam int OFFSET_W = offset_w(CACHE_LINE_SIZE);
  localparam int INDEX_W  = index_w(CACHE_SIZE);
  localparam int TAG_W    = tag_w(AW, CACHE_SIZE, CACHE_LINE_SIZE);

  generate
    if (TAG_W < 1) begin : g_bad_geometry
      $error("cached_ram: address too narrow for cache index and offset fields");
    end
  endgenerate

  typedef struct packed {
    logic                                       valid;
    logic [TAG_W-1:0]                           tag;
    logic [CACHE_LINE_SIZE-1:0][DATA_WIDTH-1:0] data;
  } line_t;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;

  assign offset = addr[OFFSET_W-1:0];
  assign index  = addr[OFFSET_W +: INDEX_W];
  assign tag    = addr[AW-1 -: TAG_W];

  line_t                                      cache_q [CACHE_SIZE];
  line_t                                      cache_d [CACHE_SIZE];
  logic [DATA_WIDTH-1:0]                      data_out_q;
  logic [DATA_WIDTH-1:0]                      data_out_d;
  logic [CACHE_LINE_SIZE-1:0][DATA_WIDTH-1:0] mem_line;
  logic [CACHE_LINE_SIZE-1:0][DATA_WIDTH-1:0] fill_line;
  line_t                                      cur_line;
  logic                                       hit;

  cached_ram_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (AW),
    .LINE_SIZE  (CACHE_LINE_SIZE)
  ) u_store (
    .clk       (clk),
    .wr_en     (writeEnable && !reset),
    .wr_addr   (addr),
    .wr_data   (dataIn),
    .line_addr ({tag, index}),
    .line_data (mem_line)
  );

  // Every access (re)installs the addressed line, so hits and misses share one path:
  // the line source is the cache on a hit and the backing memory on a miss.
  always_comb begin
    cache_d    = cache_q;
    data_out_d = data_out_q;
    cur_line   = cache_q[index];
    hit        = cur_line.valid && (cur_line.tag == tag);
    fill_line  = hit ? cur_line.data : mem_line;

    if (writeEnable) begin
      fill_line[offset] = dataIn;
      data_out_d        = dataIn;
    end else begin
      data_out_d = fill_line[offset];
    end

    cache_d[index].valid = 1'b1;
    cache_d[index].tag   = tag;
    cache_d[index].data  = fill_line;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CACHE_SIZE; i++) begin
        cache_q[i].valid <= 1'b0;
      end
      data_out_q <= '0;
    end else begin
      cache_q    <= cache_d;
      data_out_q <= data_out_d;
    end
  end

  assign dataOut = data_out_q;

endmodule

// File: tb/tb_cached_ram.sv
// Directed and randomized checks of cached_ram against hand-computed values and a word model.
module tb_cached_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] addr;
  logic [7:0] dataIn;
  logic       writeEnable;
  logic [7:0] dataOut;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] model [128];

  cached_ram #(
    .DATA_WIDTH      (8),
    .ADDR_WIDTH      (8),
    .CACHE_SIZE      (16),
    .CACHE_LINE_SIZE (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .dataIn      (dataIn),
    .writeEnable (writeEnable),
    .dataOut     (dataOut)
  );

  always #5 clk = ~clk;

  // One access: drive, take the edge, sample 1 time unit later.
  task automatic op(input logic rst, input logic we, input logic [6:0] a, input logic [7:0] d);
    reset       = rst;
    writeEnable = we;
    addr        = a;
    dataIn      = d;
    @(posedge clk);
    #1;
    if (we && !rst) model[a] = d;
    reset       = 1'b0;
    writeEnable = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    compared++;
    assert (dataOut === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, dataOut, exp);
    end
    $display("txn %s addr=%h we=%0d dataOut=%h exp=%h", tag, addr, writeEnable, dataOut, exp);
  endtask

  initial begin
    logic       we;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] exp;

    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    reset = 1'b1; writeEnable = 1'b0; addr = '0; dataIn = '0;

    // Reset state
    op(1'b1, 1'b0, 7'h00, 8'h00);
    op(1'b1, 1'b0, 7'h00, 8'h00);
    check("reset_dataout", 8'h00);

    // 1: fill a line with FF, read it back
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b1, 7'(i), 8'hFF);
      check($sformatf("t1_wr%0d", i), 8'hFF);
    end
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b0, 7'(i), 8'h00);
      check($sformatf("t1_rd%0d", i), 8'hFF);
    end

    // 2: conflicting lines at the same index
    op(1'b0, 1'b1, 7'h05, 8'h11); check("t2_wr05", 8'h11);
    op(1'b0, 1'b1, 7'h45, 8'h22); check("t2_wr45", 8'h22);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b0, 7'h05, 8'h00); check("t2_rd05", 8'h11);
      op(1'b0, 1'b0, 7'h45, 8'h00); check("t2_rd45", 8'h22);
    end

    // 3: memory survives reset, cache refills
    op(1'b0, 1'b1, 7'h10, 8'hA5); check("t3_wr10", 8'hA5);
    op(1'b1, 1'b0, 7'h10, 8'h00); check("t3_reset", 8'h00);
    op(1'b0, 1'b0, 7'h10, 8'h00); check("t3_rd10", 8'hA5);
    op(1'b0, 1'b0, 7'h05, 8'h00); check("t3_rd05", 8'h11);

    // 4: top address, write-first then read-after-write
    op(1'b0, 1'b1, 7'h7F, 8'h3C); check("t4_wr7f", 8'h3C);
    op(1'b0, 1'b0, 7'h7F, 8'h00); check("t4_rd7f", 8'h3C);

    // 5: write during reset is dropped
    op(1'b1, 1'b1, 7'h20, 8'h99); check("t5_reset_wr", 8'h00);
    op(1'b0, 1'b0, 7'h20, 8'h00); check("t5_rd20", 8'h00);

    // Write hit on a freshly read line, then neighbour word unaffected
    op(1'b0, 1'b1, 7'h21, 8'h5A); check("hit_wr21", 8'h5A);
    op(1'b0, 1'b0, 7'h20, 8'h00); check("hit_rd20", 8'h00);
    op(1'b0, 1'b0, 7'h21, 8'h00); check("hit_rd21", 8'h5A);

    // 6: random mix against the word model
    for (int n = 0; n < 1000; n++) begin
      we  = 1'($urandom_range(0, 1));
      a   = 7'($urandom_range(0, 127));
      d   = 8'($urandom_range(0, 255));
      exp = we ? d : model[a];
      op(1'b0, we, a, d);
      check($sformatf("rnd%0d", n), exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cached_ram.md
Name: cached_ram

Overview:
- Word-addressable synchronous RAM with an internal direct-mapped, write-through, write-allocate cache in front of a backing memory array.
- Cache refill is single-cycle, so the block behaves externally as a 1-cycle-latency synchronous RAM. The cache exists for structure and later latency modelling.
- Serves as a drop-in memory for simple datapaths and processor models.

Parameters:
- DATA_WIDTH, 8, width of one data word in bits.
- ADDR_WIDTH, 8, address-space parameter; the addr port is ADDR_WIDTH-1 bits; backing depth is 2**(ADDR_WIDTH-1) words.
- CACHE_SIZE, 16, number of cache lines; power of two.
- CACHE_LINE_SIZE, 4, words per cache line; power of two.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  ADDR_WIDTH-1  word address.
- dataIn  input  DATA_WIDTH  write data.
- writeEnable  input  1  1 = write dataIn to addr this cycle; 0 = read addr.
- dataOut  output  DATA_WIDTH  registered read data.

Behaviour:
- Address split, MSB to LSB: tag | index | offset.
  - offset = clog2(CACHE_LINE_SIZE) bits.
  - index = clog2(CACHE_SIZE) bits.
  - tag = remaining bits (defaults: 1 | 4 | 2).
  - Requires ADDR_WIDTH-1 > offset+index bits; this is an elaboration-time check.
- State per line: valid bit, tag, CACHE_LINE_SIZE data words. The backing memory is a flat word array.
- Reset is synchronous and has priority over everything:
  - clears all valid bits;
  - sets dataOut = 0;
  - leaves backing memory contents unchanged.
- Reset mid-operation: a write in the same cycle as reset is dropped; memory keeps its prior value.
- Hit = valid[index] && tag matches.
- Read (writeEnable=0), on the clock edge:
  - hit: dataOut <= cache word;
  - miss: the whole line is loaded from backing memory (words at {tag,index,0..LINE-1}), valid set, tag updated, and dataOut <= backing word.
  - Latency is one cycle: addr is sampled on edge N and data is visible after edge N.
- Write (writeEnable=1), on the clock edge:
  - backing memory[addr] <= dataIn (write-through).
  - hit: the cache word is updated.
  - miss: the line is allocated, filled from backing memory with the addressed word replaced by dataIn, valid set.
  - dataOut <= dataIn (write-first).
- Eviction: no write-back is needed, because the cache is never dirty.
- Back-to-back accesses to any mix of addresses are allowed, one per cycle, with no stalls and no handshake.
- Coherence: the cache and the backing memory must always agree for valid lines. A read after a write to the same address in the next cycle returns the new data.
- Address wrap: none. The full addr range maps 1:1 to backing memory.
- Unwritten backing words are initialised to 0 at time zero, not on reset.

Decomposition:
- Package cached_ram_pkg holds:
  - localparam functions for OFFSET_W, INDEX_W, TAG_W;
  - typedef cache_line_t (valid, tag, data array).
- One sub-module is natural: cached_ram_store, the backing memory. It has one write port and a combinational whole-line read of CACHE_LINE_SIZE words.
- Tag compare, allocation and the dataOut register live in the top module.

Test Plan:
1. Reset, then write 8'hFF to addresses 0..3 on consecutive cycles, then read 0..3 on consecutive cycles -> dataOut = 8'hFF one cycle after each read address.
2. Write 0x11 to addr 0x05 and 0x22 to addr 0x45 (same index, different tag), then read 0x05 and 0x45 alternately -> 0x11 and 0x22 respectively each time; conflict misses return correct data.
3. Write 0xA5 to addr 0x10, assert reset for one cycle, then read 0x10 -> dataOut = 0 during the reset cycle, then 0xA5 (memory survives reset, cache refilled).
4. Write 0x3C to addr 0x7F, then read 0x7F in the next cycle -> 0x3C; also check dataOut = 0x3C during the write cycle (write-first).
5. Assert writeEnable=1 with reset=1 for addr 0x20, data 0x99, then release reset and read 0x20 -> 0x00; the write was dropped.
6. Random mix of 1000 reads and writes versus a golden array model -> every dataOut matches the model with 1-cycle latency.
